// File: rtl/apb_host_bridge_pkg.sv
// apb_host_bridge_pkg: widths and the registered command record of the host-to-APB bridge
package apb_host_bridge_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: SoC-wide APB request/response struct types shared by all APB masters and slaves
package soc_bus_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } soc_apb_req_t;
  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } soc_apb_resp_t;
endpackage

// File: rtl/apb_host_bridge_if.sv
// apb_host_bridge_if: bundle of the bridge's command, response and APB signals
//   master : command issuer (drives cmd_*, rsp_ready; sees cmd_ready, rsp_*)
//   slave  : the bridge side of the command/response handshakes
//   apb    : downstream APB slave (sees apb_req, drives apb_rsp)
interface apb_host_bridge_if;
  import apb_host_bridge_pkg::*;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [ADDR_W-1:0]           cmd_addr;
  logic                        cmd_write;
  logic [DATA_W-1:0]           cmd_wdata;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  soc_bus_pkg::soc_apb_req_t   apb_req;
  soc_bus_pkg::soc_apb_resp_t  apb_rsp;
  modport master (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport apb (
    input  apb_req,
    output apb_rsp
  );
endinterface

// File: rtl/apb_host_bridge.sv
// apb_host_bridge: single-outstanding valid/ready command to APB master bridge with access timeout
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   cmd_*                 : command handshake and payload (accepted only in IDLE)
//   rsp_*                 : response handshake, read data and error (slave error or timeout)
//   apb_req_o, apb_rsp_i  : APB master port
module apb_host_bridge
  import apb_host_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter type apb_req_t = soc_bus_pkg::soc_apb_req_t,
  parameter type apb_rsp_t = soc_bus_pkg::soc_apb_resp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_write_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output apb_req_t          apb_req_o,
  input  apb_rsp_t          apb_rsp_i
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // cnt_q holds the number of ACCESS cycles already spent without pready,
  // so the last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) begin
        cmd_d   = '{addr: cmd_addr_i, write: cmd_write_i, wdata: cmd_wdata_i};
        state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (apb_rsp_i.pready) begin
        rdata_d = cmd_q.write ? '0 : apb_rsp_i.prdata;
        err_d   = apb_rsp_i.pslverr;
        cnt_d   = '0;
        state_d = RESP;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        rdata_d = '0;
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Gating with rst_ni keeps cmd_ready low for the whole reset interval,
  // not only after the first clock edge.
  assign cmd_ready_o = rst_ni && (state_q == IDLE);
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  always_comb begin
    apb_req_o         = '0;
    apb_req_o.paddr   = cmd_q.addr;
    apb_req_o.pwrite  = cmd_q.write;
    apb_req_o.pwdata  = cmd_q.wdata;
    apb_req_o.psel    = (state_q == SETUP) || (state_q == ACCESS);
    apb_req_o.penable = state_q == ACCESS;
  end
endmodule

// File: tb/tb_apb_host_bridge.sv
// tb_apb_host_bridge: scoreboard bench for apb_host_bridge against a small memory-backed APB slave
module tb_apb_host_bridge;
  import apb_host_bridge_pkg::*;
  import soc_bus_pkg::*;
  localparam int unsigned TO = 4;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic stall = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] mem [16] = '{default: 32'h0};
  exp_t sb[$];
  apb_host_bridge_if bif();
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  apb_host_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (bif.cmd_valid),
    .cmd_ready_o (bif.cmd_ready),
    .cmd_addr_i  (bif.cmd_addr),
    .cmd_write_i (bif.cmd_write),
    .cmd_wdata_i (bif.cmd_wdata),
    .rsp_valid_o (bif.rsp_valid),
    .rsp_ready_i (bif.rsp_ready),
    .rsp_rdata_o (bif.rsp_rdata),
    .rsp_err_o   (bif.rsp_err),
    .apb_req_o   (bif.apb_req),
    .apb_rsp_i   (bif.apb_rsp)
  );
  // Slave: pready is driven in every state (unless stalled) so a bridge that
  // sampled it outside ACCESS would shorten the transfer.
  always_comb begin
    bif.apb_rsp         = '0;
    bif.apb_rsp.pready  = !stall;
    bif.apb_rsp.pslverr = bif.apb_req.paddr[31:28] != 4'h1;
    bif.apb_rsp.prdata  = bif.apb_rsp.pslverr ? 32'h0 : mem[bif.apb_req.paddr[5:2]];
  end
  always @(posedge clk_i)
    if (bif.apb_req.psel && bif.apb_req.penable && bif.apb_rsp.pready && bif.apb_req.pwrite && !bif.apb_rsp.pslverr)
      mem[bif.apb_req.paddr[5:2]] <= bif.apb_req.pwdata;

  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input bit push);
    int n = 0;
    @(negedge clk_i);
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = a;
    bif.cmd_write = w;
    bif.cmd_wdata = d;
    while (!bif.cmd_ready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (!bif.cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", bif.cmd_ready);
    end else if (push) sb.push_back('{er, ee});
    @(posedge clk_i);
    #1 bif.cmd_valid = 1'b0;
  endtask

  task automatic collect(input int hold, output int lat, output int ns, output int na, output logic [31:0] pw);
    exp_t e;
    lat = 0; ns = 0; na = 0; pw = '0;
    do begin
      @(negedge clk_i);
      lat++;
      if (bif.apb_req.psel && !bif.apb_req.penable) ns++;
      if (bif.apb_req.psel && bif.apb_req.penable) begin
        na++;
        pw = bif.apb_req.pwdata;
      end
    end while (!bif.rsp_valid && lat < 50);
    checks++;
    if (!bif.rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 50 cycles", bif.rsp_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected_rsp: rdata=%h err=%b with no expected entry", bif.rsp_rdata, bif.rsp_err);
      e = '0;
    end else e = sb.pop_front();
    checks++;
    if (bif.rsp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL rsp_rdata: got %h required %h", bif.rsp_rdata, e.rdata);
    end
    checks++;
    if (bif.rsp_err !== e.err) begin
      errors++;
      $display("FAIL rsp_err: got %b required %b", bif.rsp_err, e.err);
    end
    checks++;
    if ({bif.cmd_ready, bif.apb_req.psel, bif.apb_req.penable} !== 3'b000) begin
      errors++;
      $display("FAIL resp_quiet: cmd_ready/psel/penable=%b required 000", {bif.cmd_ready, bif.apb_req.psel, bif.apb_req.penable});
    end
    repeat (hold) begin
      @(negedge clk_i);
      checks++;
      if ({bif.rsp_valid, bif.cmd_ready, bif.apb_req.psel, bif.apb_req.penable} !== 4'b1000) begin
        errors++;
        $display("FAIL hold_ctrl: valid/ready/psel/penable=%b required 1000", {bif.rsp_valid, bif.cmd_ready, bif.apb_req.psel, bif.apb_req.penable});
      end
      checks++;
      if (bif.rsp_rdata !== e.rdata || bif.rsp_err !== e.err) begin
        errors++;
        $display("FAIL hold_data: rdata=%h err=%b required %h %b", bif.rsp_rdata, bif.rsp_err, e.rdata, e.err);
      end
    end
    bif.rsp_ready = 1'b1;
    @(posedge clk_i);
    #1 bif.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bif.cmd_ready, bif.rsp_valid, bif.rsp_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/err=%b required 000", {bif.cmd_ready, bif.rsp_valid, bif.rsp_err});
    end
    checks++;
    if (bif.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 0", bif.rsp_rdata);
    end
    checks++;
    if (bif.apb_req !== '0) begin
      errors++;
      $display("FAIL reset_apb_req: got %h required 0", bif.apb_req);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: cmd_ready=%b required 1", bif.cmd_ready);
    end
  endtask

  task automatic test_write();
    int lat, ns, na;
    logic [31:0] pw;
    send(32'h1000_0000, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    collect(0, lat, ns, na, pw);
    checks++;
    if (ns != 1 || na != 1) begin
      errors++;
      $display("FAIL write_phases: setup=%0d access=%0d required 1 1", ns, na);
    end
    checks++;
    if (pw !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL write_pwdata: got %h required cafef00d", pw);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL write_latency: got %0d required 3", lat);
    end
  endtask

  task automatic test_read();
    int lat, ns, na;
    logic [31:0] pw;
    send(32'h1000_0000, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    collect(0, lat, ns, na, pw);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL read_latency: got %0d required 3", lat);
    end
  endtask

  task automatic test_slverr();
    int lat, ns, na;
    logic [31:0] pw;
    send(32'hFFFF_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    collect(0, lat, ns, na, pw);
    @(negedge clk_i);
    checks++;
    if (bif.cmd_ready !== 1'b1 || bif.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL slverr_idle: ready=%b valid=%b required 1 0", bif.cmd_ready, bif.rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int lat, ns, na;
    logic [31:0] pw;
    send(32'h1000_0004, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
    collect(0, lat, ns, na, pw);
    stall = 1'b1;
    send(32'h1000_0004, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    collect(0, lat, ns, na, pw);
    stall = 1'b0;
    checks++;
    if (na != TO) begin
      errors++;
      $display("FAIL timeout_access: got %0d access cycles required %0d", na, TO);
    end
    checks++;
    if (lat != TO + 2) begin
      errors++;
      $display("FAIL timeout_latency: got %0d required %0d", lat, TO + 2);
    end
  endtask

  task automatic test_resp_hold();
    int lat, ns, na;
    logic [31:0] pw;
    send(32'h1000_0004, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
    collect(5, lat, ns, na, pw);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int n = 0;
    int k = 0;
    bit accept;
    exp_t e;
    int lat, ns, na;
    logic [31:0] pw;
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 32'h1000_0020;
    bif.cmd_wdata = 32'hA0A0_0000;
    while ((k < 3 || sb.size() > 0) && n < 40) begin
      @(negedge clk_i);
      n++;
      if (bif.rsp_valid) begin
        e = (sb.size() > 0) ? sb.pop_front() : '1;
        checks++;
        if (bif.rsp_rdata !== e.rdata || bif.rsp_err !== e.err) begin
          errors++;
          $display("FAIL b2b_rsp: rdata=%h err=%b required %h %b", bif.rsp_rdata, bif.rsp_err, e.rdata, e.err);
        end
      end
      accept = bif.cmd_valid && bif.cmd_ready;
      if (accept) begin
        sb.push_back('{32'h0, 1'b0});
        acc.push_back(cyc);
      end
      @(posedge clk_i);
      #1;
      if (accept) begin
        k++;
        if (k == 3) bif.cmd_valid = 1'b0;
        else begin
          bif.cmd_addr  = bif.cmd_addr + 32'd4;
          bif.cmd_wdata = bif.cmd_wdata + 32'd1;
        end
      end
    end
    bif.cmd_valid = 1'b0;
    bif.rsp_ready = 1'b0;
    checks++;
    if (acc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts required 3", acc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d %0d required 4 4", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send(32'h1000_0020 + 32'(4 * i), 1'b0, 32'h0, 32'hA0A0_0000 + 32'(i), 1'b0, 1'b1);
      collect(0, lat, ns, na, pw);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int seen = 0;
    int lat, ns, na;
    logic [31:0] pw;
    stall = 1'b1;
    send(32'h1000_0030, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    while (!(bif.apb_req.psel && bif.apb_req.penable) && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    checks++;
    if (!(bif.apb_req.psel && bif.apb_req.penable)) begin
      errors++;
      $display("FAIL mid_access: psel/penable=%b%b required 11", bif.apb_req.psel, bif.apb_req.penable);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (bif.apb_req !== '0 || bif.rsp_valid !== 1'b0 || bif.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: apb_req=%h valid=%b ready=%b required 0 0 0", bif.apb_req, bif.rsp_valid, bif.cmd_ready);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (8) begin
      @(negedge clk_i);
      if (bif.rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abandoned_rsp: rsp_valid seen %0d cycles required 0", seen);
    end
    send(32'h1000_0034, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    collect(0, lat, ns, na, pw);
    stall = 1'b0;
    checks++;
    if (na != TO) begin
      errors++;
      $display("FAIL counter_cleared: got %0d access cycles required %0d", na, TO);
    end
  endtask

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_write = 1'b0;
    bif.cmd_wdata = '0;
    bif.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_slverr();
    test_timeout();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected responses never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_host_bridge.md
APB_HOST_BRIDGE -- requirements
Module: apb_host_bridge

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 256, meaning ACCESS-phase cycles allowed before a forced error response (minimum 1).
REQ-002 SHALL provide parameter apb_req_t, default soc_bus_pkg::soc_apb_req_t, meaning the APB request struct driven downstream.
REQ-003 SHALL provide parameter apb_rsp_t, default soc_bus_pkg::soc_apb_resp_t, meaning the APB response struct received from downstream.
REQ-004 SHALL provide port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL provide ports cmd_valid_i (input, 1) and cmd_ready_o (output, 1), the command handshake.
REQ-007 SHALL provide ports cmd_addr_i (input, 32), cmd_write_i (input, 1) and cmd_wdata_i (input, 32), the command payload.
REQ-008 SHALL provide ports rsp_valid_o (output, 1) and rsp_ready_i (input, 1), the response handshake.
REQ-009 SHALL provide ports rsp_rdata_o (output, 32), read data, and rsp_err_o (output, 1), slave error or timeout.
REQ-010 SHALL provide ports apb_req_o (output, apb_req_t) and apb_rsp_i (input, apb_rsp_t), the APB master port.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-012 SHALL assert cmd_ready_o only in IDLE; a command is accepted on cmd_valid_i && cmd_ready_o.
REQ-013 SHALL, on acceptance, register addr/write/wdata and go IDLE->SETUP; payload SHALL stay stable until the response completes.
REQ-014 SHALL drive psel=1, penable=0 in SETUP for exactly one cycle, then go to ACCESS.
REQ-015 SHALL drive psel=1, penable=1 in ACCESS until pready=1 or timeout.
REQ-016 SHALL, on pready=1 in ACCESS, capture prdata (reads; 0 for writes) and pslverr into response registers and go to RESP.
REQ-017 SHALL count ACCESS cycles; when the count reaches TIMEOUT_CYCLES without pready, rsp_err_o=1, rsp_rdata_o=0, go to RESP.
REQ-018 SHALL drive psel=0, penable=0 in IDLE and RESP; paddr/pwrite/pwdata hold the registered command in all states.
REQ-019 SHALL hold rsp_valid_o=1 with stable data in RESP until rsp_ready_i=1, then return to IDLE.
REQ-020 SHALL give minimum latency of 3 cycles from acceptance edge to rsp_valid_o (SETUP, ACCESS with pready=1, RESP).
REQ-021 SHALL NOT accept a new command in the RESP->IDLE cycle; back-to-back throughput is one command per 4 cycles minimum.
REQ-022 SHALL ignore apb_rsp_i outside ACCESS.
REQ-023 SHALL drive all remaining apb_req_t fields to 0.

Reset
REQ-024 SHALL, on rst_ni low, immediately enter IDLE and drive cmd_ready_o=0 while in reset, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 and apb_req_o all-zero.
REQ-025 SHALL, on reset mid-transfer, abandon the transfer with no response produced; the timeout counter SHALL clear to 0.

Structure
REQ-026 SHALL keep the APB struct types in soc_bus_pkg; the FSM state enum SHALL be local to the module.
REQ-027 SHALL be a single module with no sub-modules; the timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-028 Write 0x1000_0000 <= 0xCAFE_F00D, slave pready immediate -> one SETUP and one ACCESS cycle with pwdata=0xCAFE_F00D; rsp_err_o=0 three cycles after acceptance.
REQ-029 Read 0x1000_0000 after the write, against a slave that stores the written value -> rsp_rdata_o=0xCAFE_F00D, rsp_err_o=0.
REQ-030 Read an unmapped address 0xFFFF_0000 with pslverr=1 -> rsp_err_o=1, FSM returns to IDLE after rsp_ready_i.
REQ-031 Slave pready held at 0, TIMEOUT_CYCLES=4 -> exactly 4 ACCESS cycles, then psel=0, rsp_err_o=1, rsp_rdata_o=0.
REQ-032 rsp_ready_i held at 0 for 5 cycles in RESP -> rsp_valid_o/data stable, cmd_ready_o=0, no APB activity; rst_ni pulsed during ACCESS -> apb_req_o=0 asynchronously, no response.
